// File: rtl/stream_rescale_pkg.sv
// -----------------------------------------------------------------------------
// stream_rescale_pkg
// Shared definitions for the stream_rescale_gen lane-width converter.
//   lane_t    : default lane type (LANE_WIDTH bits)
//   cnt_width : number of bits needed to hold a count in 0..max_count
//   popcount  : number of set bits in a keep mask (up to 64 lanes)
//   min_int   : minimum of two integers
// -----------------------------------------------------------------------------
package stream_rescale_pkg;

  localparam int LANE_WIDTH = 4;

  typedef logic [LANE_WIDTH-1:0] lane_t;

  // Counts include the full value max_count, hence the +1.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int popcount(input logic [63:0] vec);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      if (vec[i]) c++;
    end
    return c;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/stream_rescale_gen_compactor.sv
// -----------------------------------------------------------------------------
// lane_compactor
// Combinational: gathers the kept lanes of one input beat into the low
// positions of packed_lanes, in ascending input-lane order.
// Ports:
//   s_data       in   S_KEEP_WIDTH lanes of T_DATA_WIDTH bits
//   s_keep       in   lane valid mask, any pattern
//   packed_lanes out  compacted lanes, unused upper lanes are zero
//   lane_count   out  number of kept lanes (popcount of s_keep)
// -----------------------------------------------------------------------------
module lane_compactor
  import stream_rescale_pkg::*;
#(
  parameter int T_DATA_WIDTH = 4,
  parameter int S_KEEP_WIDTH = 4,
  parameter int K_WIDTH      = cnt_width(S_KEEP_WIDTH)
) (
  input  logic [T_DATA_WIDTH-1:0] s_data       [S_KEEP_WIDTH],
  input  logic [S_KEEP_WIDTH-1:0] s_keep,
  output logic [T_DATA_WIDTH-1:0] packed_lanes [S_KEEP_WIDTH],
  output logic [K_WIDTH-1:0]      lane_count
);

  // rank counts the kept lanes seen so far; a kept lane lands at slot rank.
  always_comb begin : compact
    logic [K_WIDTH-1:0] rank;
    packed_lanes = '{default: '0};
    rank         = '0;
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      if (s_keep[i]) begin
        for (int j = 0; j < S_KEEP_WIDTH; j++) begin
          if (rank == K_WIDTH'(j)) packed_lanes[j] = s_data[i];
        end
        rank = rank + K_WIDTH'(1);
      end
    end
  end

  assign lane_count = K_WIDTH'(popcount(64'(s_keep)));

endmodule

// File: rtl/stream_rescale_gen.sv
// -----------------------------------------------------------------------------
// stream_rescale_gen
// AXI-Stream lane-width converter, S_KEEP_WIDTH input lanes to M_KEEP_WIDTH
// output lanes. Kept input lanes are compacted into a lane buffer; full
// M-lane beats are emitted as soon as available, plus a short (possibly
// empty) final beat when a packet ends. Counts completed output packets.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   s_data_i     input lanes (unpacked lane array)
//   s_keep_i     input lane mask, any pattern
//   s_last_i     final input beat of packet
//   s_valid_i    input valid
//   s_ready_o    input ready (registered state and rst_n only)
//   m_data_o     output lanes, unused lanes zero
//   m_keep_o     thermometer mask, low lanes first
//   m_last_o     final output beat of packet
//   m_valid_o    output valid
//   m_ready_i    output ready
//   pkt_cnt_o    completed output packets, wraps
// -----------------------------------------------------------------------------
module stream_rescale_gen
  import stream_rescale_pkg::*;
#(
  parameter int T_DATA_WIDTH  = 4,
  parameter int S_KEEP_WIDTH  = 4,
  parameter int M_KEEP_WIDTH  = 7,
  parameter int BUF_LANES     = 12,
  parameter int PKT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [T_DATA_WIDTH-1:0]  s_data_i [S_KEEP_WIDTH],
  input  logic [S_KEEP_WIDTH-1:0]  s_keep_i,
  input  logic                     s_last_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [T_DATA_WIDTH-1:0]  m_data_o [M_KEEP_WIDTH],
  output logic [M_KEEP_WIDTH-1:0]  m_keep_o,
  output logic                     m_last_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [PKT_CNT_WIDTH-1:0] pkt_cnt_o
);

  localparam int CW = cnt_width(BUF_LANES);
  localparam int KW = cnt_width(S_KEEP_WIDTH);

  // A shallower buffer cannot guarantee a free input slot while a full
  // output beat is waiting, which would starve the stream.
  generate
    if (BUF_LANES < S_KEEP_WIDTH + M_KEEP_WIDTH - 1) begin : g_depth_check
      $error("stream_rescale_gen: BUF_LANES must be >= S_KEEP_WIDTH+M_KEEP_WIDTH-1");
    end
  endgenerate

  logic [T_DATA_WIDTH-1:0]  lane_buf [BUF_LANES];
  logic [CW-1:0]            cnt;
  logic                     last_pend;
  logic [PKT_CNT_WIDTH-1:0] pkt_cnt;

  logic [T_DATA_WIDTH-1:0]  packed_lanes [S_KEEP_WIDTH];
  logic [KW-1:0]            in_k;
  logic [CW-1:0]            n;
  logic [CW-1:0]            shift_n;
  logic [CW-1:0]            base;
  logic [CW-1:0]            cnt_next;
  logic                     accept;
  logic                     emit;
  logic [T_DATA_WIDTH-1:0]  ext_buf  [BUF_LANES + M_KEEP_WIDTH];
  logic [T_DATA_WIDTH-1:0]  shifted  [BUF_LANES];
  logic [T_DATA_WIDTH-1:0]  next_buf [BUF_LANES];

  lane_compactor #(
    .T_DATA_WIDTH (T_DATA_WIDTH),
    .S_KEEP_WIDTH (S_KEEP_WIDTH),
    .K_WIDTH      (KW)
  ) u_compactor (
    .s_data       (s_data_i),
    .s_keep       (s_keep_i),
    .packed_lanes (packed_lanes),
    .lane_count   (in_k)
  );

  // Handshake and output view, all derived from registered state.
  assign n         = CW'(min_int(int'(cnt), M_KEEP_WIDTH));
  assign s_ready_o = rst_n && !last_pend && (int'(cnt) + S_KEEP_WIDTH <= BUF_LANES);
  assign m_valid_o = (int'(cnt) >= M_KEEP_WIDTH) || last_pend;
  assign m_last_o  = last_pend && (int'(cnt) <= M_KEEP_WIDTH);
  assign pkt_cnt_o = pkt_cnt;
  assign accept    = s_valid_i && s_ready_o;
  assign emit      = m_valid_o && m_ready_i;
  assign shift_n   = emit ? n : '0;
  assign base      = cnt - shift_n;
  assign cnt_next  = cnt - shift_n + (accept ? CW'(in_k) : '0);

  always_comb begin
    m_keep_o = '0;
    m_data_o = '{default: '0};
    for (int i = 0; i < M_KEEP_WIDTH; i++) begin
      if (CW'(i) < n) begin
        m_keep_o[i] = 1'b1;
        m_data_o[i] = lane_buf[i];
      end
    end
  end

  // Zero-padded copy of the buffer so every shift amount 0..M indexes in range.
  always_comb begin
    ext_buf = '{default: '0};
    for (int i = 0; i < BUF_LANES; i++) ext_buf[i] = lane_buf[i];
  end

  // Shift down by the emitted lane count; lanes above cnt are kept zero, so
  // the vacated top fills with zeros.
  always_comb begin
    shifted = '{default: '0};
    for (int i = 0; i < BUF_LANES; i++) begin
      for (int s = 0; s <= M_KEEP_WIDTH; s++) begin
        if (shift_n == CW'(s)) shifted[i] = ext_buf[i + s];
      end
    end
  end

  // Appended lanes land directly after the surviving lanes (index cnt-n).
  always_comb begin
    next_buf = shifted;
    if (accept) begin
      for (int i = 0; i < BUF_LANES; i++) begin
        for (int j = 0; j < S_KEEP_WIDTH; j++) begin
          if ((KW'(j) < in_k) && (int'(base) + j == i)) next_buf[i] = packed_lanes[j];
        end
      end
    end
  end

  // last_pend set and clear cannot coincide: accept needs !last_pend,
  // while a last beat needs last_pend.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_buf  <= '{default: '0};
      cnt       <= '0;
      last_pend <= 1'b0;
      pkt_cnt   <= '0;
    end else begin
      lane_buf <= next_buf;
      cnt      <= cnt_next;
      if (accept && s_last_i) begin
        last_pend <= 1'b1;
      end else if (emit && m_last_o) begin
        last_pend <= 1'b0;
      end
      if (emit && m_last_o) pkt_cnt <= pkt_cnt + PKT_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_stream_rescale_gen.sv
// -----------------------------------------------------------------------------
// tb_stream_rescale_gen
// Scoreboard bench for stream_rescale_gen. Accepted input lanes are pushed
// into a lane queue; a monitor compares every output cycle against the head
// of that queue and pops on each output handshake.
// -----------------------------------------------------------------------------
module tb_stream_rescale_gen;
  import stream_rescale_pkg::*;

  localparam int T = 4;
  localparam int S = 4;
  localparam int M = 7;
  localparam int B = 12;
  localparam int P = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [T-1:0] s_data [S];
  logic [S-1:0] s_keep;
  logic         s_last;
  logic         s_valid;
  logic         s_ready;
  logic [T-1:0] m_data [M];
  logic [M-1:0] m_keep;
  logic         m_last;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [P-1:0] pkt_cnt;

  int           checks = 0;
  int           errors = 0;
  int           ready_mode = 1;
  lane_t        exp_lanes [$];
  bit           exp_last_pend = 1'b0;
  logic [P-1:0] exp_pkt = '0;

  always #5 clk = ~clk;

  stream_rescale_gen #(
    .T_DATA_WIDTH  (T),
    .S_KEEP_WIDTH  (S),
    .M_KEEP_WIDTH  (M),
    .BUF_LANES     (B),
    .PKT_CNT_WIDTH (P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_keep_i  (s_keep),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_keep_o  (m_keep),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .pkt_cnt_o (pkt_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one beat (lane i in lanes[i*T +: T]) and hold it until accepted.
  task automatic applyStimulus(input logic [S*T-1:0] lanes, input logic [S-1:0] keep, input logic last);
    bit accepted;
    int cycles;
    for (int i = 0; i < S; i++) s_data[i] = lanes[i*T +: T];
    s_keep   = keep;
    s_last   = last;
    s_valid  = 1'b1;
    accepted = 1'b0;
    cycles   = 0;
    while (!accepted && cycles < 200) begin
      @(posedge clk);
      accepted = s_ready;
      cycles++;
      #1;
    end
    s_valid = 1'b0;
    checkOutput("accept_within_bound", 64'(accepted), 64'd1);
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk);
      #1;
      done = (exp_lanes.size() == 0) && !exp_last_pend;
    end
    checkOutput("drain_within_bound", 64'(done), 64'd1);
  endtask

  // Output ready pattern: 0 stalled, 1 always ready, 2 random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Input side of the scoreboard: record kept lanes of every accepted beat.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_lanes.delete();
      exp_last_pend = 1'b0;
      exp_pkt       = '0;
    end else if (s_valid && s_ready) begin
      for (int i = 0; i < S; i++) begin
        if (s_keep[i]) exp_lanes.push_back(s_data[i]);
      end
      if (s_last) exp_last_pend = 1'b1;
    end
  end

  // Output monitor: compare the visible beat with the queue head, pop on transfer.
  always @(negedge clk) begin : monitor
    int          n;
    bit          exp_valid;
    bit          exp_last;
    bit          exp_ready;
    logic [63:0] exp_data;
    logic [63:0] act_data;
    logic [63:0] exp_keep;
    if (!rst_n) begin
      checkOutput("s_ready_in_reset", 64'(s_ready), 64'd0);
    end else begin
      n         = min_int(exp_lanes.size(), M);
      exp_valid = (exp_lanes.size() >= M) || exp_last_pend;
      exp_last  = exp_last_pend && (exp_lanes.size() <= M);
      exp_ready = !exp_last_pend && (exp_lanes.size() + S <= B);
      exp_keep  = (64'd1 << n) - 64'd1;
      exp_data  = '0;
      act_data  = '0;
      for (int i = 0; i < M; i++) begin
        if (i < n) exp_data[i*T +: T] = exp_lanes[i];
        act_data[i*T +: T] = m_data[i];
      end
      checkOutput("s_ready", 64'(s_ready), 64'(exp_ready));
      checkOutput("m_valid", 64'(m_valid), 64'(exp_valid));
      checkOutput("m_keep", 64'(m_keep), exp_keep);
      checkOutput("m_last", 64'(m_last), 64'(exp_last));
      checkOutput("m_data", act_data, exp_data);
      checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));
      if (exp_valid && m_ready) begin
        for (int i = 0; i < n; i++) void'(exp_lanes.pop_front());
        if (exp_last) begin
          exp_last_pend = 1'b0;
          exp_pkt       = exp_pkt + P'(1);
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_keep  = '1;
    s_last  = 1'b0;
    for (int i = 0; i < S; i++) s_data[i] = T'(i + 1);

    // Reset with s_valid held high.
    repeat (2) @(posedge clk);
    #1;
    s_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    checkOutput("reset_m_valid", 64'(m_valid), 64'd0);
    checkOutput("reset_m_keep", 64'(m_keep), 64'd0);
    checkOutput("reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
    @(posedge clk);
    #1;

    // Dense beats, then an empty last beat flushes the leftover lane.
    ready_mode = 1;
    applyStimulus({4'd4, 4'd3, 4'd2, 4'd1}, 4'b1111, 1'b0);
    applyStimulus({4'd8, 4'd7, 4'd6, 4'd5}, 4'b1111, 1'b0);
    applyStimulus('0, 4'b0000, 1'b1);
    waitDrain();

    // Sparse last beat under a short stall.
    ready_mode = 0;
    applyStimulus({4'hA, 4'h0, 4'hB, 4'h0}, 4'b1010, 1'b1);
    repeat (3) @(posedge clk);
    ready_mode = 1;
    #1;
    waitDrain();

    // Backpressure: fill to 12 lanes, a 4th beat waits until release.
    ready_mode = 0;
    for (int b = 0; b < 3; b++) begin
      applyStimulus({T'(4*b+4), T'(4*b+3), T'(4*b+2), T'(4*b+1)}, 4'b1111, 1'b0);
    end
    fork
      begin
        repeat (8) @(posedge clk);
        ready_mode = 1;
      end
    join_none
    applyStimulus({4'hF, 4'hE, 4'hD, 4'hC}, 4'b1111, 1'b0);
    applyStimulus('0, 4'b0000, 1'b1);
    waitDrain();

    // Zero-length packet on an empty buffer.
    applyStimulus({4'h5, 4'h5, 4'h5, 4'h5}, 4'b0000, 1'b1);
    waitDrain();

    // Reset with 5 lanes buffered, then a fresh packet.
    applyStimulus({4'h4, 4'h3, 4'h2, 4'h1}, 4'b1111, 1'b0);
    applyStimulus({4'h0, 4'h0, 4'h0, 4'h5}, 4'b0001, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset_m_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus({4'hC, 4'hB, 4'hA, 4'h9}, 4'b1111, 1'b1);
    waitDrain();

    // Randomized traffic with random output backpressure.
    ready_mode = 2;
    for (int it = 0; it < 300; it++) begin
      applyStimulus((S*T)'($urandom), S'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    applyStimulus('0, 4'b0000, 1'b1);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
